collision_tracker: RTL and testbench

- Parametrised, frame-synchronous collision detector for the object layer.
- Samples per-pixel draw requests from the character, NUM_ARROWS arrows and NUM_BUBBLES bubbles during the raster scan, and accumulates border and object-overlap events over a whole frame.
- Reports the accumulated events as registered one-cycle pulses after each startOfFrame.
- Adds a post-hit shield window and per-arrow hit arbitration; sits between the object drawers and the object move/split controllers.

---
 rtl/collision_tracker.sv | 182 ++++++++++++++++++
 tb/tb_collision_tracker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/collision_tracker.sv
// Frame-synchronous collision detector: accumulates border/overlap events over a frame and
// reports them as one-cycle pulses after startOfFrame. Optional: COLLISION_OVERLAP_THRESHOLD_EN.
module collision_tracker #(
  parameter int unsigned NUM_BUBBLES   = 4,
  parameter int unsigned NUM_ARROWS    = 2,
  parameter int unsigned X_FRAME_SIZE  = 639,
  parameter int unsigned Y_FRAME_SIZE  = 479,
  parameter int unsigned SHIELD_FRAMES = 60,
  parameter int unsigned MIN_OVERLAP   = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                startOfFrame,
  input  logic [10:0]                         pixelX,
  input  logic [10:0]                         pixelY,
  input  logic                                charDrawingRequest,
  input  logic [NUM_ARROWS-1:0]               arrowDrawingRequest,
  input  logic [NUM_BUBBLES-1:0]              bubbleDrawingRequest,
  output logic                                charCrashLeft,
  output logic                                charCrashRight,
  output logic [NUM_ARROWS-1:0]               arrowHitTop,
  output logic [NUM_BUBBLES-1:0]              bubbleHitChar,
  output logic [NUM_ARROWS*NUM_BUBBLES-1:0]   arrowHitBubble,
  output logic                                shieldActive,
  output logic                                anyHit
);

  localparam int unsigned NumAb = NUM_ARROWS * NUM_BUBBLES;
  localparam int unsigned ShW   = (SHIELD_FRAMES > 0) ? $clog2(SHIELD_FRAMES + 1) : 1;
  localparam logic [ShW-1:0] ShLoad = ShW'(SHIELD_FRAMES);
  localparam logic [10:0]    XLast  = 11'(X_FRAME_SIZE);

  typedef enum logic [0:0] {StSync, StAccum} state_e;

  state_e r_state, w_state_d;

  logic                   r_left, r_right;
  logic [NUM_ARROWS-1:0]  r_top;
  logic [NumAb-1:0]       r_ab;
  logic [ShW-1:0]         r_shield, w_shield_d;

  logic                   r_out_left, r_out_right, r_out_shield, r_out_any;
  logic [NUM_ARROWS-1:0]  r_out_top;
  logic [NUM_BUBBLES-1:0] r_out_char;
  logic [NumAb-1:0]       r_out_ab;

  logic                   w_ev_left, w_ev_right;
  logic [NUM_ARROWS-1:0]  w_ev_top;
  logic [NUM_BUBBLES-1:0] w_ev_char;
  logic [NumAb-1:0]       w_ev_ab;
  logic                   w_report, w_keep, w_sample;
  logic [NUM_BUBBLES-1:0] w_char_frame, w_char_rep;
  logic [NumAb-1:0]       w_ab_arb;
  logic [NUM_ARROWS-1:0]  w_row_hit;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StSync:  if (startOfFrame) w_state_d = StAccum;
      StAccum: w_state_d = StAccum;
      default: w_state_d = StSync;
    endcase
  end

  always_comb begin
    w_ev_left  = charDrawingRequest && (pixelX == 11'd0);
    w_ev_right = charDrawingRequest && (pixelX == XLast);
    w_ev_top   = arrowDrawingRequest & {NUM_ARROWS{pixelY == 11'd0}};
    w_ev_char  = bubbleDrawingRequest & {NUM_BUBBLES{charDrawingRequest}};
    w_ev_ab    = '0;
    for (int unsigned a = 0; a < NUM_ARROWS; a++) begin
      for (int unsigned b = 0; b < NUM_BUBBLES; b++) begin
        w_ev_ab[a*NUM_BUBBLES+b] = arrowDrawingRequest[a] & bubbleDrawingRequest[b];
      end
    end
  end

  // The startOfFrame cycle opens the new frame: accumulators restart from its events.
  assign w_report = (r_state == StAccum) && startOfFrame;
  assign w_keep   = (r_state == StAccum) && !startOfFrame;
  assign w_sample = (r_state == StAccum) || startOfFrame;

`ifdef COLLISION_OVERLAP_THRESHOLD_EN
  localparam int unsigned OvW = (MIN_OVERLAP > 0) ? $clog2(MIN_OVERLAP + 1) : 1;
  localparam logic [OvW-1:0] OvMax = OvW'(MIN_OVERLAP);

  logic [OvW-1:0] r_ov   [NUM_BUBBLES];
  logic [OvW-1:0] w_ov_d [NUM_BUBBLES];

  always_comb begin
    for (int unsigned b = 0; b < NUM_BUBBLES; b++) begin
      w_ov_d[b] = w_keep ? r_ov[b] : '0;
      if (w_sample && w_ev_char[b] && (w_ov_d[b] != OvMax)) w_ov_d[b] = w_ov_d[b] + OvW'(1);
      w_char_frame[b] = (r_ov[b] >= OvMax);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NUM_BUBBLES; b++) begin
      if (reset) r_ov[b] <= '0;
      else       r_ov[b] <= w_ov_d[b];
    end
  end
`else
  logic [NUM_BUBBLES-1:0] r_char;

  assign w_char_frame = r_char;

  always_ff @(posedge clk) begin
    if (reset) r_char <= '0;
    else       r_char <= (w_keep ? r_char : '0) | (w_sample ? w_ev_char : '0);
  end
`endif

  // Each arrow reports only its lowest-index bubble.
  always_comb begin
    w_ab_arb  = '0;
    w_row_hit = '0;
    for (int unsigned a = 0; a < NUM_ARROWS; a++) begin
      for (int unsigned b = 0; b < NUM_BUBBLES; b++) begin
        if (r_ab[a*NUM_BUBBLES+b] && !w_row_hit[a]) begin
          w_ab_arb[a*NUM_BUBBLES+b] = 1'b1;
          w_row_hit[a]              = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_shield_d = r_shield;
    w_char_rep = '0;
    if (w_report) begin
      if (r_shield != '0) begin
        w_shield_d = r_shield - ShW'(1);
      end else if (|w_char_frame) begin
        w_char_rep = w_char_frame;
        w_shield_d = ShLoad;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StSync;
      r_left       <= 1'b0;
      r_right      <= 1'b0;
      r_top        <= '0;
      r_ab         <= '0;
      r_shield     <= '0;
      r_out_left   <= 1'b0;
      r_out_right  <= 1'b0;
      r_out_top    <= '0;
      r_out_char   <= '0;
      r_out_ab     <= '0;
      r_out_shield <= 1'b0;
      r_out_any    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_left       <= (w_keep & r_left) | (w_sample & w_ev_left);
      r_right      <= (w_keep & r_right) | (w_sample & w_ev_right);
      r_top        <= (w_keep ? r_top : '0) | (w_sample ? w_ev_top : '0);
      r_ab         <= (w_keep ? r_ab : '0) | (w_sample ? w_ev_ab : '0);
      r_shield     <= w_shield_d;
      r_out_left   <= w_report & r_left;
      r_out_right  <= w_report & r_right;
      r_out_top    <= w_report ? r_top : '0;
      r_out_char   <= w_char_rep;
      r_out_ab     <= w_report ? w_ab_arb : '0;
      r_out_shield <= (w_shield_d != '0);
      r_out_any    <= w_report & (r_left | r_right | (|r_top) | (|w_char_rep) | (|w_ab_arb));
    end
  end

  assign charCrashLeft  = r_out_left;
  assign charCrashRight = r_out_right;
  assign arrowHitTop    = r_out_top;
  assign bubbleHitChar  = r_out_char;
  assign arrowHitBubble = r_out_ab;
  assign shieldActive   = r_out_shield;
  assign anyHit         = r_out_any;

endmodule

// File: tb/tb_collision_tracker.sv
// Scoreboard bench for collision_tracker: a frame-level model queues the expected outputs of
// every clock edge; a negedge monitor pops and compares them.
module tb_collision_tracker;

  localparam int NB    = 4;
  localparam int NA    = 2;
  localparam int SH    = 3;
  localparam int MINOV = 8;
  localparam int OW    = 4 + NA + NB + NA * NB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset = 1'b1, startOfFrame = 1'b0, charDrawingRequest = 1'b0;
  logic [10:0]        pixelX = '0, pixelY = '0;
  logic [NA-1:0]      arrowDrawingRequest = '0;
  logic [NB-1:0]      bubbleDrawingRequest = '0;
  logic               charCrashLeft, charCrashRight, shieldActive, anyHit;
  logic [NA-1:0]      arrowHitTop;
  logic [NB-1:0]      bubbleHitChar;
  logic [NA*NB-1:0]   arrowHitBubble;
  logic [OW-1:0]      w_outs;

  collision_tracker #(
    .NUM_BUBBLES  (NB),
    .NUM_ARROWS   (NA),
    .X_FRAME_SIZE (639),
    .Y_FRAME_SIZE (479),
    .SHIELD_FRAMES(SH),
    .MIN_OVERLAP  (MINOV)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .startOfFrame        (startOfFrame),
    .pixelX              (pixelX),
    .pixelY              (pixelY),
    .charDrawingRequest  (charDrawingRequest),
    .arrowDrawingRequest (arrowDrawingRequest),
    .bubbleDrawingRequest(bubbleDrawingRequest),
    .charCrashLeft       (charCrashLeft),
    .charCrashRight      (charCrashRight),
    .arrowHitTop         (arrowHitTop),
    .bubbleHitChar       (bubbleHitChar),
    .arrowHitBubble      (arrowHitBubble),
    .shieldActive        (shieldActive),
    .anyHit              (anyHit)
  );

  assign w_outs = {charCrashLeft, charCrashRight, arrowHitTop, bubbleHitChar, arrowHitBubble,
                   shieldActive, anyHit};

  typedef struct {
    logic [OW-1:0] v;
    string         tag;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  string cur_tag  = "reset";

  task automatic check_eq(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, want);
    end
  endtask

  // Frame-level reference state
  bit              m_accum;
  bit              m_left, m_right;
  bit [NA-1:0]     m_top;
  bit [NB-1:0]     m_char;
  bit [NA*NB-1:0]  m_ab;
  int              m_ov[NB];
  int              m_sh;

  task automatic drive(input bit rst, input bit sof, input int x, input int y, input bit ch,
                       input bit [NA-1:0] ar, input bit [NB-1:0] bu);
    bit             l, r, sa, any, el, er;
    bit [NA-1:0]    t, et;
    bit [NB-1:0]    c, cf, ec;
    bit [NA*NB-1:0] ab, eab;
    exp_t           e;
    reset                = rst;
    startOfFrame         = sof;
    pixelX               = x[10:0];
    pixelY               = y[10:0];
    charDrawingRequest   = ch;
    arrowDrawingRequest  = ar;
    bubbleDrawingRequest = bu;
    @(posedge clk);
    l = 0; r = 0; t = '0; c = '0; ab = '0;
    if (rst) begin
      m_accum = 0; m_left = 0; m_right = 0; m_top = '0; m_char = '0; m_ab = '0; m_sh = 0;
      for (int b = 0; b < NB; b++) m_ov[b] = 0;
    end else begin
      if (sof && m_accum) begin
        l = m_left;
        r = m_right;
        t = m_top;
        for (int a = 0; a < NA; a++) begin
          for (int b = NB - 1; b >= 0; b--) begin
            if (m_ab[a*NB+b]) begin
              ab[a*NB+:NB] = '0;
              ab[a*NB+b]   = 1'b1;
            end
          end
        end
`ifdef COLLISION_OVERLAP_THRESHOLD_EN
        for (int b = 0; b < NB; b++) cf[b] = (m_ov[b] >= MINOV);
`else
        cf = m_char;
`endif
        if (m_sh > 0) m_sh--;
        else if (cf != 0) begin
          c    = cf;
          m_sh = SH;
        end
      end
      el  = ch && (x == 0);
      er  = ch && (x == 639);
      et  = (y == 0) ? ar : '0;
      ec  = ch ? bu : '0;
      eab = '0;
      for (int a = 0; a < NA; a++)
        for (int b = 0; b < NB; b++) eab[a*NB+b] = ar[a] && bu[b];
      if (sof) begin
        m_accum = 1; m_left = el; m_right = er; m_top = et; m_char = ec; m_ab = eab;
        for (int b = 0; b < NB; b++) m_ov[b] = ec[b] ? 1 : 0;
      end else if (m_accum) begin
        m_left |= el; m_right |= er; m_top |= et; m_char |= ec; m_ab |= eab;
        for (int b = 0; b < NB; b++) if (ec[b]) m_ov[b]++;
      end
    end
    sa    = (m_sh != 0);
    any   = l | r | (|t) | (|c) | (|ab);
    e.v   = {l, r, t, c, ab, sa, any};
    e.tag = cur_tag;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 100, 100, 0, '0, '0);
  endtask

  task automatic sof_empty();
    drive(0, 1, 100, 100, 0, '0, '0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq(e.tag, w_outs, e.v);
    end
  end

  initial begin
    repeat (3) drive(1, 0, 0, 0, 1, '1, '1);

    cur_tag = "partial_frame";
    drive(0, 0, 0, 50, 1, '0, '0);
    idle(2);
    sof_empty();
    idle(2);

    cur_tag = "crash_left";
    drive(0, 0, 0, 60, 1, '0, '0);
    idle(2);
    sof_empty();
    idle(2);

    cur_tag = "crash_right_and_beyond";
    drive(0, 0, 640, 70, 1, '0, '0);
    drive(0, 0, 2047, 70, 1, '0, '0);
    drive(0, 0, 639, 70, 1, '0, '0);
    drive(0, 0, 0, 2047, 0, 2'b11, '0);
    sof_empty();
    idle(2);

    cur_tag = "arrow_arb";
    drive(0, 0, 300, 0, 0, 2'b10, 4'b1100);
    drive(0, 0, 300, 7, 0, 2'b01, 4'b1010);
    drive(0, 0, 300, 8, 0, 2'b11, 4'b0001);
    idle(1);
    sof_empty();
    idle(2);

    cur_tag = "arrow_top_only";
    drive(0, 0, 300, 0, 0, 2'b10, 4'b1100);
    idle(1);
    sof_empty();
    idle(1);

    cur_tag = "shield";
    for (int f = 0; f < 5; f++) begin
      drive(0, 0, 200, 200, 1, '0, 4'b0001);
      idle(2);
      sof_empty();
    end
    idle(2);

    cur_tag = "sof_cycle_event";
    drive(0, 1, 0, 60, 1, '0, '0);
    idle(3);
    sof_empty();
    idle(2);

    cur_tag = "reset_at_report";
    drive(0, 0, 0, 0, 1, 2'b01, 4'b0110);
    idle(1);
    drive(1, 1, 100, 100, 0, '0, '0);
    idle(2);
    sof_empty();
    idle(2);
    sof_empty();
    idle(2);

    cur_tag = "overlap_7";
    repeat (7) drive(0, 0, 320, 240, 1, '0, 4'b0010);
    sof_empty();
    idle(2);

    cur_tag = "overlap_8";
    repeat (8) drive(0, 0, 320, 240, 1, '0, 4'b0100);
    sof_empty();
    idle(3);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
